// File: rtl/imem_loader.sv
// imem_loader: boot loader turning a big-endian byte stream into instruction-memory writes.
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA_HI,
        DATA_LO,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE,
        ERR
    } state_t;
    state_t      state;
    logic [15:0] count;
    logic [7:0]  hi;
    logic [15:0] n;
    logic        last;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  chk;
`endif
    assign in_ready = state != DONE && state != ERR;
    assign n        = {count[15:8], in_data};
    assign last     = 32'(words_loaded) + 1 == 32'(count);
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= HDR_HI;
            count        <= '0;
            hi           <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_rst      <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk          <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            if (in_valid && in_ready) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                chk <= chk ^ in_data;
`endif
                case (state)
                    HDR_HI: begin
                        count[15:8] <= in_data;
                        state       <= HDR_LO;
                    end
                    HDR_LO: begin
                        count[7:0] <= in_data;
                        if (n == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state <= CHK;
`else
                            state   <= DONE;
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
`endif
                        end else if ({16'd0, n} > DEPTH) begin
                            state <= ERR;
                            error <= 1'b1;
                        end else begin
                            state <= DATA_HI;
                        end
                    end
                    DATA_HI: begin
                        hi    <= in_data;
                        state <= DATA_LO;
                    end
                    DATA_LO: begin
                        imem_we      <= 1'b1;
                        imem_addr    <= words_loaded[ADDR_WIDTH-1:0];
                        imem_wdata   <= {hi, in_data};
                        words_loaded <= words_loaded + 1'b1;
                        if (!last) begin
                            state <= DATA_HI;
                        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state <= CHK;
`else
                            state   <= DONE;
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
`endif
                        end
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    CHK: begin
                        state   <= in_data == chk ? DONE : ERR;
                        done    <= in_data == chk;
                        error   <= in_data != chk;
                        cpu_rst <= in_data != chk;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized stream checks of imem_loader against a stream-level reference model.
module tb_imem_loader;
    localparam int AW = 11;
    localparam int DEPTH = 1 << AW;
    typedef logic [7:0] bq_t[$];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_wdata;
    logic          cpu_rst;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_rst(cpu_rst),
        .done(done), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] wa[$];
    logic [15:0]   wd[$];
    int            wc[$];
    int            done_cyc = -1;
    int            last_xfer = 0;
    always @(negedge clk) begin
        if (imem_we) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
            wc.push_back(cyc);
        end
        if (done && done_cyc < 0) done_cyc = cyc;
    end

    int n_cmp = 0;
    int n_bad = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wa.delete();
        wd.delete();
        wc.delete();
        done_cyc = -1;
    endtask

    // mode 0: valid every cycle, 1: valid on alternate cycles, 2: random gaps
    task automatic send(input bq_t s, input int mode);
        int i = 0;
        int guard = 0;
        while (i < s.size() && guard < 20000) begin
            @(negedge clk);
            guard++;
            in_valid = mode == 0 ? 1'b1 : mode == 1 ? ((cyc % 2) == 0) : ($urandom_range(0, 2) != 0);
            in_data = in_valid ? s[i] : 8'($urandom);
            if (!in_ready) break;
            if (in_valid) begin
                last_xfer = cyc;
                i++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("accepted", i, s.size());
    endtask

    function automatic bq_t with_cs(input bq_t s);
        bq_t r = s;
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] x = 8'h00;
        foreach (s[i]) x ^= s[i];
        r.push_back(x);
`endif
        return r;
    endfunction

    task automatic run(input string tag, input bq_t s, input int mode);
        logic [15:0] n;
        int          avail, nw, bad_gap;
        bit          ovf, full, ok, err;
        logic [7:0]  x;
        do_reset();
        check({tag, "_rst_cpu"}, cpu_rst, 1);
        check({tag, "_rst_rdy"}, in_ready, 1);
        check({tag, "_rst_words"}, words_loaded, 0);
        send(s, mode);
        repeat (3) @(negedge clk);
        n = {s[0], s[1]};
        ovf = int'(n) > DEPTH;
        avail = (s.size() - 2) / 2;
        nw = ovf ? 0 : (int'(n) < avail ? int'(n) : avail);
        full = !ovf && avail >= int'(n);
        ok = full;
        x = 8'h00;
`ifdef IMEM_LOADER_CHECKSUM_EN
        for (int i = 0; i < 2 + 2 * nw; i++) x ^= s[i];
        full = full && s.size() > 2 + 2 * int'(n);
        ok = full && s[2 + 2 * int'(n)] == x;
`endif
        err = ovf || (full && !ok);
        check({tag, "_nwr"}, wa.size(), nw);
        for (int i = 0; i < nw && i < wa.size(); i++) begin
            check({tag, "_addr"}, wa[i], i);
            check({tag, "_data"}, wd[i], {s[2 + 2 * i], s[3 + 2 * i]});
        end
        check({tag, "_done"}, done, ok);
        check({tag, "_error"}, error, err);
        check({tag, "_cpu_rst"}, cpu_rst, !ok);
        check({tag, "_words"}, words_loaded, nw);
        check({tag, "_ready"}, in_ready, !(ok || err));
        if (nw > 0) begin
            check({tag, "_hold_addr"}, imem_addr, nw - 1);
            check({tag, "_hold_data"}, imem_wdata, {s[2 * nw], s[2 * nw + 1]});
        end
        if (ok) check({tag, "_done_lat"}, done_cyc, last_xfer + 1);
`ifndef IMEM_LOADER_CHECKSUM_EN
        if (ok && nw > 0 && wc.size() == nw) check({tag, "_last_wr_cyc"}, wc[nw - 1], done_cyc);
`endif
        if (mode == 0 && wc.size() > 1) begin
            bad_gap = 0;
            for (int i = 1; i < wc.size(); i++) if (wc[i] - wc[i - 1] != 2) bad_gap++;
            check({tag, "_gap"}, bad_gap, 0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t s;
        int  n;
        run("two", with_cs('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD}), 0);
        run("zero", with_cs('{8'h00, 8'h00}), 0);
        run("ovf", '{8'h08, 8'h01}, 0);
        run("toggle", with_cs('{8'h00, 8'h01, 8'h5A, 8'hA5}), 1);
        do_reset();
        send('{8'h00, 8'h03, 8'h11, 8'h22, 8'h33}, 0);
        repeat (2) @(negedge clk);
        check("mid_nwr", wa.size(), 1);
        check("mid_words", words_loaded, 1);
        do_reset();
        check("mid_we", imem_we, 0);
        check("mid_addr", imem_addr, 0);
        check("mid_wdata", imem_wdata, 0);
        check("mid_cpu_rst", cpu_rst, 1);
        check("mid_done", done, 0);
        check("mid_error", error, 0);
        check("mid_words0", words_loaded, 0);
        check("mid_ready", in_ready, 1);
        run("reload", with_cs('{8'h00, 8'h01, 8'h77, 8'h88}), 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        run("cs_good", '{8'h00, 8'h01, 8'h12, 8'h34, 8'h27}, 0);
        run("cs_bad", '{8'h00, 8'h01, 8'h12, 8'h34, 8'h00}, 0);
`endif
        for (int k = 0; k < 10; k++) begin
            n = $urandom_range(0, 6);
            s = '{8'(n >> 8), 8'(n)};
            for (int i = 0; i < 2 * n; i++) s.push_back(8'($urandom));
            run("rnd", with_cs(s), $urandom_range(0, 2));
        end
        n = $urandom_range(DEPTH + 1, 65535);
        run("rnd_ovf", '{8'(n >> 8), 8'(n)}, 2);
        s = '{8'(DEPTH >> 8), 8'(DEPTH)};
        for (int i = 0; i < 2 * DEPTH; i++) s.push_back(8'($urandom));
        run("full", with_cs(s), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader: the writing end of the instruction-memory interface that the processor's fetch stage reads.
- Accepts a byte stream over a valid/ready handshake and assembles 16-bit instruction words.
- Writes the words into instruction memory at consecutive addresses starting at 0.
- Holds the processor in reset until the image is fully loaded; releases it only on success.

Parameters:
- ADDR_WIDTH, 11, instruction-memory address width; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 16, instruction word width; fixed at 2 bytes per word.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  byte on in_data is valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- imem_we  output  1  instruction-memory write enable, one cycle per word.
- imem_addr  output  ADDR_WIDTH  write address.
- imem_wdata  output  DATA_WIDTH  write data.
- cpu_rst  output  1  reset to the processor; high until load succeeds.
- done  output  1  load completed successfully; sticky until rst.
- error  output  1  load failed; sticky until rst.
- words_loaded  output  ADDR_WIDTH+1  count of words written so far.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Handshake: a byte transfers on a rising edge where in_valid && in_ready. in_ready is combinational from state only: 1 in HDR_HI, HDR_LO, DATA_HI, DATA_LO, CHK; 0 in DONE and ERR. in_data is ignored when no transfer occurs.
- Stream format, big-endian: 2-byte word count N, then N words sent high byte first, then (optional feature only) 1 checksum byte.
- Reset values: state HDR_HI, imem_we 0, imem_addr 0, imem_wdata 0, cpu_rst 1, done 0, error 0, words_loaded 0, count 0, checksum 0.
- FSM transitions, each taken on byte transfer:
  - HDR_HI: latch count[15:8]; go to HDR_LO.
  - HDR_LO: latch count[7:0], giving N.
    - N == 0: go to DONE (or CHK with the feature).
    - N > 2**ADDR_WIDTH: go to ERR; no writes occur.
    - Otherwise: go to DATA_HI.
  - DATA_HI: latch the high byte; go to DATA_LO.
  - DATA_LO: on the next cycle imem_we = 1, imem_wdata = {hi, byte}, imem_addr = words_loaded (pre-increment value); words_loaded increments. Then:
    - Words still remaining after this one: go to DATA_HI.
    - Last word: go to DONE (or CHK with the feature).
  - DONE: done = 1, cpu_rst = 0; absorbing until rst.
  - ERR: error = 1, cpu_rst = 1; absorbing until rst.
- Write timing:
  - Write latency is exactly 1 cycle after the low-byte transfer.
  - imem_we is a single-cycle pulse per word.
  - imem_addr and imem_wdata hold their last values when imem_we = 0.
- Burst rate: at most one byte per cycle. Back-to-back valid bytes load one word per 2 cycles with no bubbles.
- Address range: addresses never wrap. N == 2**ADDR_WIDTH writes 0 through depth-1 and terminates; words_loaded is wide enough to reach depth.
- Output transitions:
  - done and cpu_rst change on the clock edge that enters DONE.
  - The final imem_we pulse occurs in the same cycle that done first reads 1.
- Reset mid-load: on rst the block returns to reset values on the next edge and cpu_rst stays 1. Any partial byte or word is discarded. Memory contents already written are not cleared; the next load overwrites them from address 0.
- rst asserted in DONE re-enters HDR_HI with cpu_rst = 1 (reload supported).

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR covers every header and data byte.
  - After the last word, or immediately after HDR_LO when N == 0, the FSM enters CHK and accepts one byte.
  - Byte equals the running XOR: go to DONE.
  - Byte differs: go to ERR; cpu_rst stays 1. Words already written remain in memory.
- Undefined: the CHK state and checksum register are absent, and the FSM goes directly to DONE after the last word.

Test Plan:
- Stream 00 02 12 34 AB CD, in_valid held high: imem_we pulses at addr 0 = 0x1234 and addr 1 = 0xABCD, 2 cycles apart; done = 1 and cpu_rst = 0 one cycle after the final byte; words_loaded = 2; in_ready = 0 afterwards.
- Stream 00 00: no imem_we; done = 1 after the second byte (checksum build: after a third byte of 0x00).
- Stream 08 01 (N = 2049 > 2048): error = 1, cpu_rst = 1, no writes, in_ready = 0.
- Stream 00 01 5A A5 with in_valid toggled every other cycle: exactly one write at addr 0 = 0x5AA5; bytes are not duplicated or lost across idle cycles.
- rst asserted after 00 03 11 22 33 (one word written, half of the second word received): all outputs return to reset values. Restream 00 01 77 88: single write at addr 0 = 0x7788, then done.
- IMEM_LOADER_CHECKSUM_EN: stream 00 01 12 34 followed by 0x27 gives done = 1; the same stream followed by 0x00 gives error = 1 with cpu_rst = 1.
